voice_allocator: RTL and testbench

Polyphonic voice scheduler for the AudioVoice synth. It accepts note-on/note-off events and assigns each note to one of NUM_VOICES voice instances, driving each voice's level trigger and note/velocity configuration. When all voices are in use it steals the least-recently-allocated voice. It sits between the event source (MIDI/AXI-lite decoder) and the bank of voices whose AXI-Stream outputs carry the voice ID on tid.

---
 rtl/voice_allocator_if.sv | 30 +++
 rtl/voice_allocator.sv | 206 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// rtl/voice_allocator_if.sv - event, voice-bank and allocation signals of the voice allocator
interface voice_allocator_if #(
  parameter int NUM_VOICES = 8,
  parameter int VID_W      = 3,
  parameter int NOTE_W     = 7,
  parameter int VEL_W      = 7
);
  logic                         ev_valid;
  logic                         ev_ready;
  logic                         ev_on;
  logic [NOTE_W-1:0]            ev_note;
  logic [VEL_W-1:0]             ev_vel;
  logic [NUM_VOICES-1:0]        voice_busy;
  logic [NUM_VOICES-1:0]        voice_trigger;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note;
  logic [NUM_VOICES*VEL_W-1:0]  voice_vel;
  logic                         alloc_valid;
  logic [VID_W-1:0]             alloc_vid;
  logic                         alloc_steal;

  modport master (
    output ev_valid, ev_on, ev_note, ev_vel, voice_busy,
    input  ev_ready, voice_trigger, voice_note, voice_vel, alloc_valid, alloc_vid, alloc_steal
  );

  modport slave (
    input  ev_valid, ev_on, ev_note, ev_vel, voice_busy,
    output ev_ready, voice_trigger, voice_note, voice_vel, alloc_valid, alloc_vid, alloc_steal
  );
endinterface

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice scheduler with LRU stealing and retrigger gap
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int VID_W      = 3,
  parameter int NOTE_W     = 7,
  parameter int VEL_W      = 7
) (
  input  logic             fast_clk,
  input  logic             resetn,
  voice_allocator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, GAP, COMMIT} state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [VID_W-1:0]      r_idx;
  logic                  r_on;
  logic [NOTE_W-1:0]     r_note;
  logic [VEL_W-1:0]      r_vel;
  logic                  r_match_f, r_free_f, r_rel_f, r_old_f;
  logic [VID_W-1:0]      r_match_i, r_free_i, r_rel_i, r_old_i;
  logic [VID_W-1:0]      r_target;
  logic                  r_steal_pend;
  logic [NUM_VOICES-1:0] r_trig;
  logic [NOTE_W-1:0]     r_vnote [NUM_VOICES];
  logic [VEL_W-1:0]      r_vvel  [NUM_VOICES];
  logic [VID_W-1:0]      r_rank  [NUM_VOICES];
  logic                  r_alloc_valid;
  logic [VID_W-1:0]      r_alloc_vid;
  logic                  r_alloc_steal;

  logic                  w_handshake, w_scan_last;
  logic                  w_cur_trig, w_cur_busy;
  logic [VID_W-1:0]      w_cur_rank;
  logic                  w_match_f, w_free_f, w_rel_f, w_old_f;
  logic [VID_W-1:0]      w_match_i, w_free_i, w_rel_i, w_old_i;
  logic [VID_W-1:0]      w_target;
  logic                  w_target_gap, w_target_steal;
  logic                  w_do_commit, w_commit_steal;
  logic [VID_W-1:0]      w_commit_vid;

  assign w_handshake = (r_state == IDLE) && r_ready && bus.ev_valid;
  assign w_scan_last = (r_state == SCAN) && (r_idx == VID_W'(NUM_VOICES - 1));

  // Fold the voice under the scan index into the running candidates of each class
  always_comb begin
    w_cur_trig = r_trig[r_idx];
    w_cur_busy = bus.voice_busy[r_idx];
    w_cur_rank = r_rank[r_idx];
    w_match_f  = r_match_f;
    w_match_i  = r_match_i;
    w_free_f   = r_free_f;
    w_free_i   = r_free_i;
    w_rel_f    = r_rel_f;
    w_rel_i    = r_rel_i;
    w_old_f    = r_old_f;
    w_old_i    = r_old_i;
    if (w_cur_trig && (r_vnote[r_idx] == r_note) && !r_match_f) begin
      w_match_f = 1'b1;
      w_match_i = r_idx;
    end
    if (!w_cur_trig && !w_cur_busy && !r_free_f) begin
      w_free_f = 1'b1;
      w_free_i = r_idx;
    end
    if (!w_cur_trig && w_cur_busy && (!r_rel_f || (w_cur_rank > r_rank[r_rel_i]))) begin
      w_rel_f = 1'b1;
      w_rel_i = r_idx;
    end
    if (w_cur_trig && (!r_old_f || (w_cur_rank > r_rank[r_old_i]))) begin
      w_old_f = 1'b1;
      w_old_i = r_idx;
    end
  end

  // Pick the note-on target (retrigger, free, releasing, then oldest held) and the commit source
  always_comb begin
    w_target       = w_old_i;
    w_target_gap   = 1'b1;
    w_target_steal = 1'b1;
    if (w_match_f) begin
      w_target       = w_match_i;
      w_target_steal = 1'b0;
    end else if (w_free_f) begin
      w_target       = w_free_i;
      w_target_gap   = 1'b0;
      w_target_steal = 1'b0;
    end else if (w_rel_f) begin
      w_target       = w_rel_i;
      w_target_gap   = 1'b0;
      w_target_steal = 1'b0;
    end
    w_do_commit    = (w_scan_last && r_on && !w_target_gap) || (r_state == GAP);
    w_commit_vid   = (r_state == GAP) ? r_target : w_target;
    w_commit_steal = (r_state == GAP) ? r_steal_pend : 1'b0;
  end

  // Allocation FSM; commit effects are registered on entry to COMMIT so they show during COMMIT
  always_ff @(posedge fast_clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_ready       <= 1'b0;
      r_idx         <= '0;
      r_on          <= 1'b0;
      r_note        <= '0;
      r_vel         <= '0;
      r_match_f     <= 1'b0;
      r_free_f      <= 1'b0;
      r_rel_f       <= 1'b0;
      r_old_f       <= 1'b0;
      r_match_i     <= '0;
      r_free_i      <= '0;
      r_rel_i       <= '0;
      r_old_i       <= '0;
      r_target      <= '0;
      r_steal_pend  <= 1'b0;
      r_trig        <= '0;
      r_alloc_valid <= 1'b0;
      r_alloc_vid   <= '0;
      r_alloc_steal <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_vnote[v] <= '0;
        r_vvel[v]  <= '0;
        r_rank[v]  <= VID_W'(v);
      end
    end else begin
      r_alloc_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_handshake) begin
            r_ready   <= 1'b0;
            r_on      <= bus.ev_on;
            r_note    <= bus.ev_note;
            r_vel     <= bus.ev_vel;
            r_match_f <= 1'b0;
            r_free_f  <= 1'b0;
            r_rel_f   <= 1'b0;
            r_old_f   <= 1'b0;
            r_idx     <= '0;
            r_state   <= SCAN;
          end
        end
        SCAN: begin
          r_match_f <= w_match_f;
          r_match_i <= w_match_i;
          r_free_f  <= w_free_f;
          r_free_i  <= w_free_i;
          r_rel_f   <= w_rel_f;
          r_rel_i   <= w_rel_i;
          r_old_f   <= w_old_f;
          r_old_i   <= w_old_i;
          r_idx     <= r_idx + 1'b1;
          if (w_scan_last) begin
            if (!r_on) begin
              if (w_match_f) r_trig[w_match_i] <= 1'b0;
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else if (w_target_gap) begin
              r_trig[w_target] <= 1'b0;
              r_target         <= w_target;
              r_steal_pend     <= w_target_steal;
              r_state          <= GAP;
            end else begin
              r_state <= COMMIT;
            end
          end
        end
        GAP: r_state <= COMMIT;
        COMMIT: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_do_commit) begin
        r_trig[w_commit_vid]  <= 1'b1;
        r_vnote[w_commit_vid] <= r_note;
        r_vvel[w_commit_vid]  <= r_vel;
        r_alloc_valid         <= 1'b1;
        r_alloc_vid           <= w_commit_vid;
        r_alloc_steal         <= w_commit_steal;
        for (int u = 0; u < NUM_VOICES; u++) begin
          if (r_rank[u] < r_rank[w_commit_vid]) r_rank[u] <= r_rank[u] + 1'b1;
        end
        r_rank[w_commit_vid] <= '0;
      end
    end
  end

  // Pack per-voice note/velocity registers onto the bank buses
  always_comb begin
    bus.voice_note = '0;
    bus.voice_vel  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      bus.voice_note[v*NOTE_W +: NOTE_W] = r_vnote[v];
      bus.voice_vel[v*VEL_W +: VEL_W]    = r_vvel[v];
    end
  end

  assign bus.ev_ready      = r_ready;
  assign bus.voice_trigger = r_trig;
  assign bus.alloc_valid   = r_alloc_valid;
  assign bus.alloc_vid     = r_alloc_vid;
  assign bus.alloc_steal   = r_alloc_steal;
endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator
module tb_voice_allocator;
  localparam int NV = 8;
  localparam int NW = 7;
  localparam int VW = 7;

  typedef struct {
    int vid;
    int steal;
    int note;
    int vel;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [NW-1:0] m_note [NV];
  logic [VW-1:0] m_vel  [NV];
  logic [NV-1:0] m_trig;

  voice_allocator_if #(.NUM_VOICES(NV), .VID_W(3), .NOTE_W(NW), .VEL_W(VW)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .VID_W(3), .NOTE_W(NW), .VEL_W(VW)) dut (
    .fast_clk (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every allocation pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (resetn && bus.alloc_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL alloc_unexpected: pulse with vid %0d and no pending expectation (cycle %0d)", bus.alloc_vid, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("alloc_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("alloc_vid", 64'(bus.alloc_vid), 64'(mon_e.vid));
        check("alloc_steal", 64'(bus.alloc_steal), 64'(mon_e.steal));
        check("alloc_trigger", 64'(bus.voice_trigger[mon_e.vid]), 64'd1);
        check("alloc_note", 64'(bus.voice_note[mon_e.vid*NW +: NW]), 64'(mon_e.note));
        check("alloc_vel", 64'(bus.voice_vel[mon_e.vid*VW +: VW]), 64'(mon_e.vel));
      end
    end
  end

  function automatic logic [NV*NW-1:0] pack_note();
    logic [NV*NW-1:0] r;
    for (int v = 0; v < NV; v++) r[v*NW +: NW] = m_note[v];
    return r;
  endfunction

  function automatic logic [NV*VW-1:0] pack_vel();
    logic [NV*VW-1:0] r;
    for (int v = 0; v < NV; v++) r[v*VW +: VW] = m_vel[v];
    return r;
  endfunction

  task automatic model_reset();
    m_trig = '0;
    for (int v = 0; v < NV; v++) begin
      m_note[v] = '0;
      m_vel[v]  = '0;
    end
  endtask

  task automatic check_bank(input string tag);
    check({tag, "_trigger"}, 64'(bus.voice_trigger), 64'(m_trig));
    check({tag, "_note"}, 64'(bus.voice_note), 64'(pack_note()));
    check({tag, "_vel"}, 64'(bus.voice_vel), 64'(pack_vel()));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_trigger"}, 64'(bus.voice_trigger), 64'd0);
    check({tag, "_note"}, 64'(bus.voice_note), 64'd0);
    check({tag, "_vel"}, 64'(bus.voice_vel), 64'd0);
    check({tag, "_alloc_valid"}, 64'(bus.alloc_valid), 64'd0);
    check({tag, "_alloc_vid"}, 64'(bus.alloc_vid), 64'd0);
    check({tag, "_alloc_steal"}, 64'(bus.alloc_steal), 64'd0);
    check({tag, "_ev_ready"}, 64'(bus.ev_ready), 64'd0);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_ready(output int c);
    int n = 0;
    while (!bus.ev_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait_bound", 64'(bus.ev_ready), 64'd1);
    c = cyc;
  endtask

  // Offer one event at a negedge; t is the handshake cycle
  task automatic send(input logic on, input int note, input int vel, output int t);
    int c;
    @(negedge clk);
    wait_ready(c);
    bus.ev_valid = 1'b1;
    bus.ev_on    = on;
    bus.ev_note  = NW'(note);
    bus.ev_vel   = VW'(vel);
    t = cyc;
    @(negedge clk);
    bus.ev_valid = 1'b0;
  endtask

  task automatic note_on(input int note, input int vel, input int vid, input int steal, input int lat, output int t);
    send(1'b1, note, vel, t);
    exp_q.push_back('{vid: vid, steal: steal, note: note, vel: vel, cyc: t + lat});
    m_trig[vid] = 1'b1;
    m_note[vid] = NW'(note);
    m_vel[vid]  = VW'(vel);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int c;
    bus.ev_valid   = 1'b0;
    bus.ev_on      = 1'b0;
    bus.ev_note    = '0;
    bus.ev_vel     = '0;
    bus.voice_busy = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    resetn = 1'b1;

    note_on(60, 100, 0, 0, 9, t);
    wait_ready(c);
    check("free_ready_cycle", 64'(c), 64'(t + 10));

    for (int k = 1; k < NV; k++) note_on(60 + k, 10 + k, k, 0, 9, t);
    @(negedge clk);
    wait_ready(c);
    check_bank("filled");

    note_on(70, 33, 0, 1, 10, t);
    at_cyc(t + 8);
    check("steal_pre_gap", 64'(bus.voice_trigger), 64'hFF);
    @(negedge clk);
    check("steal_gap_trigger", 64'(bus.voice_trigger), 64'hFE);
    check("steal_gap_note_held", 64'(bus.voice_note[0 +: NW]), 64'd60);
    wait_ready(c);
    check("steal_ready_cycle", 64'(c), 64'(t + 11));
    check_bank("stolen");

    bus.voice_busy = 8'h04;
    send(1'b0, 62, 0, t);
    m_trig[2] = 1'b0;
    at_cyc(t + 8);
    check("off_pre_fall", 64'(bus.voice_trigger), 64'hFF);
    @(negedge clk);
    check("off_fall", 64'(bus.voice_trigger), 64'hFB);
    check("off_ready", 64'(bus.ev_ready), 64'd1);
    check_bank("note_off");

    note_on(71, 44, 2, 0, 9, t);
    @(negedge clk);
    wait_ready(c);
    bus.voice_busy = '0;
    check_bank("rel_reuse");

    note_on(60, 55, 1, 1, 10, t);
    @(negedge clk);
    wait_ready(c);
    note_on(60, 56, 1, 0, 10, t);
    at_cyc(t + 9);
    check("retrig_gap", 64'(bus.voice_trigger), 64'hFD);
    wait_ready(c);
    check_bank("retrig");

    send(1'b0, 99, 5, t);
    at_cyc(t + 9);
    check("off_miss_ready", 64'(bus.ev_ready), 64'd1);
    check_bank("off_miss");

    send(1'b1, 80, 80, t);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("mid_scan_reset");
    model_reset();
    resetn = 1'b1;

    for (int k = 0; k < NV; k++) note_on(40 + k, 20 + k, k, 0, 9, t);
    note_on(48, 90, 0, 1, 10, t);
    @(negedge clk);
    wait_ready(c);
    check_bank("after_reset");

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
